// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory master.
//   LAT_W       : width of the memory latency counter
//   lsu_size_e  : request access size encoding
//   lsu_state_e : master FSM states
package lsu_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane helper for the LSU.
//   off         : byte offset within the word (addr[1:0])
//   size        : access size
//   is_unsigned : zero-extend (1) or sign-extend (0) loads
//   wdata       : right-justified store data
//   rdata_raw   : word returned by memory
//   misalign    : illegal size or misaligned address for this size
//   wmask       : byte-lane write mask
//   wdata_lane  : store data shifted into its byte lanes
//   rdata_ext   : load data shifted down and extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        misalign,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rsh;

  always_comb begin
    rsh        = rdata_raw >> {off, 3'b000};
    wdata_lane = wdata << {off, 3'b000};
    misalign   = 1'b0;
    wmask      = 4'h0;
    rdata_ext  = 32'h0;
    case (size)
      SZ_BYTE: begin
        wmask     = 4'b0001 << off;
        rdata_ext = {{24{~is_unsigned & rsh[7]}}, rsh[7:0]};
      end
      SZ_HALF: begin
        misalign  = off[0];
        wmask     = 4'b0011 << off;
        rdata_ext = {{16{~is_unsigned & rsh[15]}}, rsh[15:0]};
      end
      SZ_WORD: begin
        misalign  = |off;
        wmask     = 4'hF;
        rdata_ext = rsh;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory master: accepts one load/store at a time, checks alignment,
// drives a fixed-latency memory port and returns an extended response.
//   clk, rst_n           : clock, async active-low reset
//   req_*                : upstream request (valid/ready handshake)
//   resp_*               : upstream response (valid/ready handshake)
//   mem_valid/mem_wen    : memory strobe and write enable
//   mem_raddr/mem_waddr  : word-aligned addresses
//   mem_wdata/mem_wmask  : lane-shifted store data and byte mask
//   mem_rdata            : word read from memory, sampled when the
//                          latency counter reaches zero
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  lsu_state_e       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  lsu_size_e        size_q, size_d;
  logic             wen_q, wen_d;
  logic             uns_q, uns_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [1:0]  al_off;
  lsu_size_e   al_size;
  logic        al_misalign;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata_lane;
  logic [31:0] al_rdata_ext;

  // One aligner serves both phases: in IDLE it sees the live request so the
  // error check can steer acceptance; afterwards it sees the registered
  // request to shape the memory access and the load data.
  always_comb begin
    if (state_q == IDLE) begin
      al_off  = req_addr[1:0];
      al_size = lsu_size_e'(req_size);
    end else begin
      al_off  = addr_q[1:0];
      al_size = size_q;
    end
  end

  lsu_align u_align (
    .off         (al_off),
    .size        (al_size),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_raw   (mem_rdata),
    .misalign    (al_misalign),
    .wmask       (al_wmask),
    .wdata_lane  (al_wdata_lane),
    .rdata_ext   (al_rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = lsu_size_e'(req_size);
          wen_d   = req_wen;
          uns_d   = req_unsigned;
          rdata_d = 32'h0;
          if (al_misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = LAT_W'(MEM_LAT);
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // The access spans MEM_LAT+1 cycles: the counter runs MEM_LAT..0 and
        // memory data is sampled during the zero cycle.
        if (cnt_q == '0) begin
          rdata_d = wen_q ? 32'h0 : al_rdata_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory outputs decode from the state register, so an async reset drops
  // them in the same instant; all payload is zeroed while idle.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state_q == ACCESS);
  assign mem_wen    = mem_valid & wen_q;
  assign mem_raddr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_waddr  = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_valid ? al_wdata_lane : 32'h0;
  assign mem_wmask  = mem_valid ? {4'h0, al_wmask} : 8'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (MEM_LAT=1 and MEM_LAT=3) share
// request payload inputs; each has its own req_valid. Directed table,
// multi-cycle corner sequences and a randomized run against a byte-level
// reference model.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid1, req_valid3, req_wen, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [1:0]  req_size;

  logic        rr1, rv1, re1, mv1, mwen1, rr3, rv3, re3, mv3, mwen3;
  logic [31:0] rd1, mra1, mwa1, mwd1, rd3, mra3, mwa3, mwd3;
  logic [7:0]  mwm1, mwm3;

  lsu_mem_master #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(rr1),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(rv1),
    .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1),
    .mem_valid(mv1), .mem_wen(mwen1), .mem_raddr(mra1), .mem_waddr(mwa1),
    .mem_wdata(mwd1), .mem_wmask(mwm1), .mem_rdata(mem_rdata));

  lsu_mem_master #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(rr3),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(rv3),
    .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(re3),
    .mem_valid(mv3), .mem_wen(mwen3), .mem_raddr(mra3), .mem_waddr(mwa3),
    .mem_wdata(mwd3), .mem_wmask(mwm3), .mem_rdata(mem_rdata));

  // view of the selected instance
  logic        sel3;
  logic        rr, rv, re, mv, mwen;
  logic [31:0] rd, mra, mwa, mwd;
  logic [7:0]  mwm;
  always_comb begin
    rr   = sel3 ? rr3   : rr1;
    rv   = sel3 ? rv3   : rv1;
    re   = sel3 ? re3   : re1;
    mv   = sel3 ? mv3   : mv1;
    mwen = sel3 ? mwen3 : mwen1;
    rd   = sel3 ? rd3   : rd1;
    mra  = sel3 ? mra3  : mra1;
    mwa  = sel3 ? mwa3  : mwa1;
    mwd  = sel3 ? mwd3  : mwd1;
    mwm  = sel3 ? mwm3  : mwm1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } model_t;

  // Reference: the access covers 2**size bytes starting at addr.
  function automatic model_t model(logic w, logic [31:0] a, logic [31:0] wd,
                                   logic [1:0] sz, logic u, logic [31:0] mrd);
    model_t m;
    int nb, off;
    longint unsigned full, v;
    nb      = 1 << sz;
    off     = int'(a % 4);
    m.err   = (sz == 2'd3) || ((a % nb) != 0);
    m.waddr = a - 32'(off);
    m.wmask = 8'(((1 << nb) - 1) << off);
    m.wdata = 32'(64'(wd) << (8 * off));
    full    = (nb >= 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 1);
    v       = (64'(mrd) >> (8 * off)) & full;
    if (!u && (((v >> (8 * nb - 1)) & 64'd1) == 64'd1)) v = v | ~full;
    m.rdata = (w || m.err) ? 32'd0 : 32'(v);
    return m;
  endfunction

  typedef struct {
    int          lat;
    logic        timeout;
    logic [31:0] rdata;
    logic        err;
    logic        seen_mv;
    logic        stable;
    logic [31:0] raddr, waddr, wdata;
    logic [7:0]  wmask;
    logic        wen;
  } res_t;

  // One full transaction with resp_ready=1. lat counts clock edges from the
  // accepting edge to the edge after which resp_valid is seen.
  task automatic run_txn(input logic l3, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic u,
                         input logic [31:0] mrd, output res_t r);
    int guard;
    r = '{default: '0};
    sel3 = l3; req_wen = w; req_addr = a; req_wdata = wd; req_size = sz;
    req_unsigned = u; mem_rdata = mrd; resp_ready = 1'b1;
    guard = 0;
    while (!rr && guard < 50) begin @(posedge clk); #1; guard++; end
    if (l3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    while (!rv && r.lat < 40) begin
      if (mv) begin
        if (!r.seen_mv) begin
          r.seen_mv = 1'b1; r.stable = 1'b1;
          r.raddr = mra; r.waddr = mwa; r.wdata = mwd; r.wmask = mwm; r.wen = mwen;
        end else if (mra !== r.raddr || mwa !== r.waddr || mwd !== r.wdata ||
                     mwm !== r.wmask || mwen !== r.wen) begin
          r.stable = 1'b0;
        end
      end
      @(posedge clk); #1;
      r.lat++;
    end
    r.timeout = !rv;
    r.rdata = rd;
    r.err = re;
    @(posedge clk); #1;
  endtask

  task automatic chk_res(input string n, input res_t r, input model_t m,
                         input logic w, input int lat);
    chk({n, ".timeout"}, 32'(r.timeout), 32'd0);
    chk({n, ".err"},     32'(r.err),     32'(m.err));
    chk({n, ".rdata"},   r.rdata,        m.rdata);
    chk({n, ".lat"},     32'(r.lat),     32'(lat));
    chk({n, ".mvalid"},  32'(r.seen_mv), 32'(!m.err));
    if (!m.err) begin
      chk({n, ".waddr"},  r.waddr,        m.waddr);
      chk({n, ".raddr"},  r.raddr,        m.waddr);
      chk({n, ".wmask"},  32'(r.wmask),   32'(m.wmask));
      chk({n, ".wdata"},  r.wdata,        m.wdata);
      chk({n, ".wen"},    32'(r.wen),     32'(w));
      chk({n, ".stable"}, 32'(r.stable),  32'd1);
    end
  endtask

  typedef struct {
    logic        l3, wen;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] mrd;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [7:0]  e_wmask;
    logic [31:0] e_wdata, e_waddr;
    int          e_lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    res_t   r;
    model_t m;
    int     guard, rises, lowrun, min_gap;
    logic   prev;

    vt[0] = '{1'b0, 1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF,
              1'b0, 32'hDEADBEEF, 8'h0F, 32'h0, 32'h80000004, 2};
    vt[1] = '{1'b0, 1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 32'h80FF1234,
              1'b0, 32'hFFFFFF80, 8'h08, 32'h0, 32'h80000000, 2};
    vt[2] = '{1'b0, 1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 32'h80FF1234,
              1'b0, 32'h00000080, 8'h08, 32'h0, 32'h80000000, 2};
    vt[3] = '{1'b0, 1'b1, 32'h80000002, 32'h0000ABCD, 2'd1, 1'b0, 32'h11111111,
              1'b0, 32'h0, 8'h0C, 32'hABCD0000, 32'h80000000, 2};
    vt[4] = '{1'b0, 1'b0, 32'h80000001, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF,
              1'b1, 32'h0, 8'h00, 32'h0, 32'h0, 0};
    vt[5] = '{1'b1, 1'b0, 32'h00000000, 32'h0, 2'd3, 1'b0, 32'h12345678,
              1'b1, 32'h0, 8'h00, 32'h0, 32'h0, 0};
    vt[6] = '{1'b1, 1'b0, 32'h10000002, 32'h0, 2'd1, 1'b0, 32'h80017FFF,
              1'b0, 32'hFFFF8001, 8'h0C, 32'h0, 32'h10000000, 4};
    vt[7] = '{1'b1, 1'b1, 32'h00000001, 32'h0000005A, 2'd0, 1'b0, 32'h0,
              1'b0, 32'h0, 8'h02, 32'h00005A00, 32'h00000000, 4};

    sel3 = 1'b0; req_valid1 = 1'b0; req_valid3 = 1'b0; req_wen = 1'b0;
    req_unsigned = 1'b0; resp_ready = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; mem_rdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.mv",   32'({mv1, mv3}),   32'd0);
    chk("rst.rv",   32'({rv1, rv3}),   32'd0);
    chk("rst.err",  32'({re1, re3}),   32'd0);
    chk("rst.rd1",  rd1, 32'd0);
    chk("rst.rd3",  rd3, 32'd0);
    chk("rst.mout", mwa1 | mra3 | mwd1 | 32'(mwm3) | 32'(mwen1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready", 32'({rr1, rr3}), 32'd3);

    // directed table
    for (int i = 0; i < 8; i++) begin
      m.err = vt[i].e_err; m.rdata = vt[i].e_rdata; m.wmask = vt[i].e_wmask;
      m.wdata = vt[i].e_wdata; m.waddr = vt[i].e_waddr;
      run_txn(vt[i].l3, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].size,
              vt[i].uns, vt[i].mrd, r);
      chk_res($sformatf("vec%0d", i), r, m, vt[i].wen, vt[i].e_lat);
    end

    // response back-pressure; a request offered during RESP must be ignored
    sel3 = 1'b0; req_wen = 1'b0; req_addr = 32'h00000006; req_size = 2'd1;
    req_unsigned = 1'b1; mem_rdata = 32'hBEEF0000; resp_ready = 1'b0;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    guard = 0;
    while (!rv && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("hold.reach", 32'(rv), 32'd1);
    req_valid1 = 1'b1; req_addr = 32'h00000040; req_size = 2'd2;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d.rv", k), 32'(rv), 32'd1);
      chk($sformatf("hold%0d.rd", k), rd, 32'h0000BEEF);
      chk($sformatf("hold%0d.rr", k), 32'(rr), 32'd0);
      @(posedge clk); #1;
    end
    req_valid1 = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold.done", 32'({rv, rr}), 32'b01);

    // back-to-back requests on MEM_LAT=3: mem_valid must drop between accesses
    sel3 = 1'b1; req_wen = 1'b0; req_addr = 32'h00000200; req_size = 2'd2;
    req_valid3 = 1'b1; resp_ready = 1'b1;
    prev = 1'b0; rises = 0; lowrun = 0; min_gap = 99;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (!mv) lowrun++;
      else begin
        if (!prev && rises > 0 && lowrun < min_gap) min_gap = lowrun;
        if (!prev) rises++;
        lowrun = 0;
      end
      prev = mv;
    end
    req_valid3 = 1'b0;
    guard = 0;
    while (!rr && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("b2b.accesses", 32'(rises >= 2), 32'd1);
    chk("b2b.gap",      32'(min_gap >= 1), 32'd1);

    // reset pulse in the second ACCESS cycle of MEM_LAT=3
    sel3 = 1'b1; req_wen = 1'b0; req_addr = 32'h00000100; req_size = 2'd2;
    mem_rdata = 32'h12345678; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.pre", 32'(mv), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.mv",  32'(mv),   32'd0);
    chk("rstmid.wen", 32'(mwen), 32'd0);
    chk("rstmid.rv",  32'({rv, re}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 32'h00000104, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, r);
    chk_res("rstmid.next", r, model(1'b0, 32'h00000104, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D),
            1'b0, 4);

    // randomized against the model
    for (int i = 0; i < 40; i++) begin
      logic        l3, w, u;
      logic [31:0] a, wd, mrd;
      logic [1:0]  sz;
      l3 = 1'($urandom); w = 1'($urandom); u = 1'($urandom);
      a = $urandom; wd = $urandom; mrd = $urandom;
      sz = 2'($urandom_range(0, 3));
      // bias toward aligned addresses so most accesses go to memory
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
      if (sz == 2'd0) wd = wd & 32'hFF;
      else if (sz == 2'd1) wd = wd & 32'hFFFF;
      m = model(w, a, wd, sz, u, mrd);
      run_txn(l3, w, a, wd, sz, u, mrd, r);
      chk_res($sformatf("rnd%0d", i), r, m, w, m.err ? 0 : (l3 ? 4 : 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: cycles mem_valid is held before mem_rdata is sampled (legal range 1..15).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: the asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: upstream request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both 1.
REQ-007 SHALL have port req_wen, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-010 SHALL have port req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 SHALL have port req_unsigned, input, 1: 1 = zero-extend a load, 0 = sign-extend it.
REQ-012 SHALL have port resp_valid, output, 1: response present.
REQ-013 SHALL have port resp_ready, input, 1: upstream accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores and for errors.
REQ-015 SHALL have port resp_err, output, 1: misaligned or illegal-size request.
REQ-016 SHALL have port mem_valid, output, 1: memory access strobe.
REQ-017 SHALL have port mem_wen, output, 1: memory write enable.
REQ-018 SHALL have port mem_raddr, output, 32: word-aligned read address.
REQ-019 SHALL have port mem_waddr, output, 32: word-aligned write address.
REQ-020 SHALL have port mem_wdata, output, 32: lane-shifted store data.
REQ-021 SHALL have port mem_wmask, output, 8: byte-lane mask; bits [7:4] are always 0.
REQ-022 SHALL have port mem_rdata, input, 32: word read from memory.

Function
REQ-023 SHALL implement the FSM states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-024 SHALL, on acceptance in IDLE, register addr, wen, wdata, size and unsigned into internal registers.
REQ-025 SHALL flag an error when req_size is 3, when req_size is 1 and addr[0] is 1, or when req_size is 2 and addr[1:0] is not 0.
REQ-026 SHALL, on an accepted request with an error, go to RESP with resp_err=1 and resp_rdata=0, and SHALL assert no memory access.
REQ-027 SHALL, on an accepted request without an error, go to ACCESS, load the latency counter with MEM_LAT, and drive mem_valid=1 from the next cycle.
REQ-028 SHALL drive mem_raddr and mem_waddr as {addr[31:2],2'b00} whenever mem_valid is 1.
REQ-029 SHALL drive mem_wen equal to the registered wen whenever mem_valid is 1.
REQ-030 SHALL drive mem_wmask as 4'b0001<<off for a byte, 4'b0011<<off for a half, and 4'hF for a word, where off = addr[1:0].
REQ-031 SHALL drive mem_wdata as wdata<<(8*off).
REQ-032 SHALL, in ACCESS, hold mem_valid and all mem_* outputs stable and decrement the counter once per cycle.
REQ-033 SHALL, on the cycle the counter reaches 0, capture mem_rdata>>(8*off), extend it to 32 bits per size and unsigned, deassert mem_valid on the next edge, and go to RESP.
REQ-034 SHALL, in RESP, hold resp_valid=1 and resp_rdata/resp_err stable until resp_ready=1, then go to IDLE.
REQ-035 SHALL give a zero-wait load a latency of MEM_LAT+1 cycles from acceptance to resp_valid.
REQ-036 SHALL keep mem_valid low for at least one cycle between consecutive accesses.
REQ-037 SHALL ignore req_* inputs outside IDLE.
REQ-038 SHALL drive mem_wen, mem_wmask, mem_wdata, mem_raddr and mem_waddr to 0 when mem_valid is 0.

Reset
REQ-039 SHALL, when rst_n=0 (including mid-ACCESS or mid-RESP), immediately go to IDLE and drop mem_valid, mem_wen, resp_valid and resp_err to 0.
REQ-040 SHALL reset resp_rdata, the counter and all registered request fields to 0.
REQ-041 SHALL drive req_ready=1 in the first cycle after reset release.

Structure
REQ-042 SHALL place the size encoding enum, the FSM state enum and the LAT_W=4 constant in the shared package lsu_pkg.
REQ-043 SHALL put store-lane alignment, load extraction and misalignment detection in one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-044 SHALL test: MEM_LAT=1, load word from 0x80000004 with mem_rdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after acceptance.
REQ-045 SHALL test: signed byte load from 0x80000003 with mem_rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-046 SHALL test: half store of 0x0000ABCD to 0x80000002 -> mem_waddr=0x80000000, mem_wmask=0x0C, mem_wdata=0xABCD0000, mem_wen=1.
REQ-047 SHALL test: word load from 0x80000001 -> resp_err=1, resp_rdata=0, and mem_valid never asserted.
REQ-048 SHALL test: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0 throughout; with MEM_LAT=3, back-to-back requests show a mem_valid low gap of at least 1 cycle.
REQ-049 SHALL test: rst_n pulsed low in the second ACCESS cycle of MEM_LAT=3 -> mem_valid=0 immediately, and the next request completes normally.
